csr_access_ctrl: RTL and testbench

- Request-side controller for the per-core CSR data block. It accepts decoded CSR instructions (CSRRW/CSRRS/CSRRC and their immediate forms) from issue and drives the CSR data block's combinational read port and registered write port as a read-modify-write.
- It returns the old CSR value to writeback through a valid/ready response.
- It is two stages deep, stalls on RAW hazards against its own pending write and on pending FPU flag updates, and provides the core "busy" indication.

---
 rtl/csr_pkg.sv | 40 ++++
 rtl/csr_rmw_alu.sv | 36 +++
 rtl/csr_access_ctrl.sv | 137 +++++++++++++
 tb/tb_csr_access_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access controller: op encodings,
// FPU-owned CSR addresses and the stage-1 pipeline payload.
package csr_pkg;

    localparam int CSR_NUM_WARPS   = 4;
    localparam int CSR_NUM_THREADS = 4;
    localparam int CSR_ADDR_W      = 12;
    localparam int CSR_NR_BITS     = 5;
    localparam int CSR_NW_BITS     = (CSR_NUM_WARPS > 1) ? $clog2(CSR_NUM_WARPS) : 1;

    typedef enum logic [1:0] {
        CSR_OP_ILLEGAL = 2'b00,
        CSR_OP_RW      = 2'b01,
        CSR_OP_RS      = 2'b10,
        CSR_OP_RC      = 2'b11
    } csr_op_e;

    localparam logic [CSR_ADDR_W-1:0] CSR_FFLAGS = 12'h001;
    localparam logic [CSR_ADDR_W-1:0] CSR_FRM    = 12'h002;
    localparam logic [CSR_ADDR_W-1:0] CSR_FCSR   = 12'h003;

    typedef struct packed {
        logic                       valid;
        logic [CSR_NW_BITS-1:0]     wid;
        logic [CSR_NUM_THREADS-1:0] tmask;
        csr_op_e                    op;
        logic [CSR_ADDR_W-1:0]      addr;
        logic [31:0]                operand;
        logic [31:0]                old;
        logic [CSR_NR_BITS-1:0]     rd;
        logic                       wb;
        logic                       write_req;
    } csr_s1_t;

    // CSRs that the FPU updates asynchronously to issue.
    function automatic logic is_fpu_csr(input logic [CSR_ADDR_W-1:0] addr);
        return (addr == CSR_FFLAGS) || (addr == CSR_FRM) || (addr == CSR_FCSR);
    endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Read-modify-write combiner: produces the new CSR value from the old
// value and the operand, truncated to the CSR data block's write width.
module csr_rmw_alu
    import csr_pkg::*;
#(
    parameter int CSR_WIDTH = 12
) (
    input  logic [1:0]           op,
    input  logic [31:0]          old_value,
    input  logic [31:0]          operand,
    output logic [CSR_WIDTH-1:0] new_value
);

    logic [31:0] full_value;

    // Select the set/clear/write combination for the current op
    always_comb begin
        // NOTE: full_value gets a default before the case so no path leaves it unassigned (no latch).
        full_value = old_value;
        case (csr_op_e'(op))
            CSR_OP_RW: full_value = operand;
            CSR_OP_RS: full_value = old_value | operand;
            CSR_OP_RC: full_value = old_value & ~operand;
            default:   full_value = old_value;
        endcase
    end

    assign new_value = full_value[CSR_WIDTH-1:0];

    // Bits above the CSR data block's width are intentionally dropped.
    if (CSR_WIDTH < 32) begin : g_trunc
        logic unused_upper;
        assign unused_upper = ^full_value[31:CSR_WIDTH];
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// Two-stage request-side controller for the per-core CSR data block.
// Stage 0 reads the CSR combinationally on accept; stage 1 holds the
// instruction, returns the old value and commits the write in the
// response handshake cycle.
module csr_access_ctrl
    import csr_pkg::*;
#(
    parameter int NUM_WARPS     = CSR_NUM_WARPS,
    parameter int NUM_THREADS   = CSR_NUM_THREADS,
    parameter int CSR_ADDR_BITS = CSR_ADDR_W,
    parameter int CSR_WIDTH     = 12,
    parameter int NR_BITS       = CSR_NR_BITS,
    localparam int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [NW_BITS-1:0]       req_wid,
    input  logic [NUM_THREADS-1:0]   req_tmask,
    input  logic [1:0]               req_op,
    input  logic                     req_use_imm,
    input  logic [4:0]               req_imm,
    input  logic [31:0]              req_rs1_data,
    input  logic                     req_rs1_is_x0,
    input  logic [CSR_ADDR_BITS-1:0] req_addr,
    input  logic [NR_BITS-1:0]       req_rd,
    input  logic                     req_wb,
    input  logic [NUM_WARPS-1:0]     fpu_pending,
    output logic                     csr_read_enable,
    output logic [CSR_ADDR_BITS-1:0] csr_read_addr,
    output logic [NW_BITS-1:0]       csr_read_wid,
    input  logic [31:0]              csr_read_data,
    output logic                     csr_write_enable,
    output logic [CSR_ADDR_BITS-1:0] csr_write_addr,
    output logic [NW_BITS-1:0]       csr_write_wid,
    output logic [CSR_WIDTH-1:0]     csr_write_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [NW_BITS-1:0]       rsp_wid,
    output logic [NUM_THREADS-1:0]   rsp_tmask,
    output logic [NR_BITS-1:0]       rsp_rd,
    output logic                     rsp_wb,
    output logic [31:0]              rsp_data,
    output logic                     busy
);

    csr_s1_t     s1_q;
    csr_s1_t     s1_d;
    logic [31:0] operand;
    logic        operand_zero;
    logic        write_req;
    logic        raw_hazard;
    logic        fpu_hazard;
    logic        stall;
    logic        accept;

    // Operand select, write qualification, hazard detection and issue handshake
    always_comb begin
        operand      = req_use_imm ? {27'd0, req_imm} : req_rs1_data;
        operand_zero = req_use_imm ? (req_imm == 5'd0) : req_rs1_is_x0;
        write_req    = 1'b0;
        case (csr_op_e'(req_op))
            CSR_OP_RW:            write_req = 1'b1;
            CSR_OP_RS, CSR_OP_RC: write_req = ~operand_zero;
            default:              write_req = 1'b0;
        endcase
        // No forwarding: a younger access to the same CSR waits for the write to land.
        raw_hazard = s1_q.valid & s1_q.write_req
                   & (s1_q.addr == req_addr) & (s1_q.wid == req_wid);
        fpu_hazard = fpu_pending[req_wid] & is_fpu_csr(req_addr);
        stall      = raw_hazard | fpu_hazard;
        req_ready  = ~reset & ~stall & (~s1_q.valid | rsp_ready);
        accept     = req_valid & req_ready;
    end

    // Assemble the stage-1 payload from the issuing request and the read data
    always_comb begin
        s1_d           = '0;
        s1_d.valid     = 1'b1;
        s1_d.wid       = req_wid;
        s1_d.tmask     = req_tmask;
        s1_d.op        = csr_op_e'(req_op);
        s1_d.addr      = req_addr;
        s1_d.operand   = operand;
        s1_d.old       = csr_read_data;
        s1_d.rd        = req_rd;
        s1_d.wb        = req_wb;
        s1_d.write_req = write_req;
    end

    // Stage-1 register: capture on accept, retire on response handshake
    always_ff @(posedge clk) begin
        // NOTE: only the valid bit is reset; the payload is qualified by it and need not be cleared.
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            s1_q.valid <= 1'b0;
        end else if (accept) begin
            s1_q <= s1_d;
        end else if (rsp_ready) begin
            s1_q.valid <= 1'b0;
        end
    end

    csr_rmw_alu #(
        .CSR_WIDTH (CSR_WIDTH)
    ) u_alu (
        .op        (s1_q.op),
        .old_value (s1_q.old),
        .operand   (s1_q.operand),
        .new_value (csr_write_data)
    );

    assign csr_read_enable  = accept;
    assign csr_read_addr    = req_addr;
    assign csr_read_wid     = req_wid;

    // The write lands exactly once, in the cycle the response is taken.
    assign csr_write_enable = s1_q.valid & s1_q.write_req & rsp_ready;
    assign csr_write_addr   = s1_q.addr;
    assign csr_write_wid    = s1_q.wid;

    assign rsp_valid = s1_q.valid;
    assign rsp_wid   = s1_q.wid;
    assign rsp_tmask = s1_q.tmask;
    assign rsp_rd    = s1_q.rd;
    assign rsp_wb    = s1_q.wb;
    assign rsp_data  = s1_q.old;

    assign busy = s1_q.valid | req_valid;

    // An illegal op is tolerated in hardware but flags a broken decoder in simulation.
    assert property (@(posedge clk) disable iff (reset)
        accept |-> (req_op != CSR_OP_ILLEGAL))
        else $error("csr_access_ctrl: illegal CSR op accepted");

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl. A small CSR block model serves
// reads and absorbs writes; a reference model predicts each response and
// write at accept time and a monitor compares them as the DUT retires.
module tb_csr_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_wid;
    logic [3:0]  req_tmask;
    logic [1:0]  req_op;
    logic        req_use_imm;
    logic [4:0]  req_imm;
    logic [31:0] req_rs1_data;
    logic        req_rs1_is_x0;
    logic [11:0] req_addr;
    logic [4:0]  req_rd;
    logic        req_wb;
    logic [3:0]  fpu_pending;
    logic        csr_read_enable;
    logic [11:0] csr_read_addr;
    logic [1:0]  csr_read_wid;
    logic [31:0] csr_read_data;
    logic        csr_write_enable;
    logic [11:0] csr_write_addr;
    logic [1:0]  csr_write_wid;
    logic [11:0] csr_write_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_wid;
    logic [3:0]  rsp_tmask;
    logic [4:0]  rsp_rd;
    logic        rsp_wb;
    logic [31:0] rsp_data;
    logic        busy;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    csr_access_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_wid          (req_wid),
        .req_tmask        (req_tmask),
        .req_op           (req_op),
        .req_use_imm      (req_use_imm),
        .req_imm          (req_imm),
        .req_rs1_data     (req_rs1_data),
        .req_rs1_is_x0    (req_rs1_is_x0),
        .req_addr         (req_addr),
        .req_rd           (req_rd),
        .req_wb           (req_wb),
        .fpu_pending      (fpu_pending),
        .csr_read_enable  (csr_read_enable),
        .csr_read_addr    (csr_read_addr),
        .csr_read_wid     (csr_read_wid),
        .csr_read_data    (csr_read_data),
        .csr_write_enable (csr_write_enable),
        .csr_write_addr   (csr_write_addr),
        .csr_write_wid    (csr_write_wid),
        .csr_write_data   (csr_write_data),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_wid          (rsp_wid),
        .rsp_tmask        (rsp_tmask),
        .rsp_rd           (rsp_rd),
        .rsp_wb           (rsp_wb),
        .rsp_data         (rsp_data),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // ---------------- CSR data block model ----------------
    logic [31:0] blk_mem [0:16383];
    logic        mem_clear = 1'b0;
    logic        pre_we    = 1'b0;
    logic [13:0] pre_idx   = '0;
    logic [31:0] pre_val   = '0;
    int          wr_count  = 0;

    assign csr_read_data = blk_mem[{csr_read_wid, csr_read_addr}];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 16384; i++) blk_mem[i] <= 32'd0;
        end
        if (pre_we) blk_mem[pre_idx] <= pre_val;
        if (csr_write_enable) begin
            blk_mem[{csr_write_wid, csr_write_addr}] <= {20'd0, csr_write_data};
            wr_count <= wr_count + 1;
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [31:0] data;
        logic [1:0]  wid;
        logic [3:0]  tmask;
        logic [4:0]  rd;
        logic        wb;
        logic        write;
        logic [11:0] waddr;
        logic [11:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [0:16383];
    int          exp_writes = 0;
    int          n_checks   = 0;
    int          n_errors   = 0;
    logic        rand_rdy   = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic predict();
        exp_t        e;
        logic [13:0] idx;
        logic [31:0] opnd;
        logic [31:0] nv;
        logic        w;
        idx  = {req_wid, req_addr};
        opnd = req_use_imm ? {27'd0, req_imm} : req_rs1_data;
        nv   = ref_mem[idx];
        w    = 1'b0;
        case (req_op)
            OP_RW: begin nv = opnd;                 w = 1'b1; end
            OP_RS: begin nv = ref_mem[idx] | opnd;  w = req_use_imm ? (req_imm != 0) : !req_rs1_is_x0; end
            OP_RC: begin nv = ref_mem[idx] & ~opnd; w = req_use_imm ? (req_imm != 0) : !req_rs1_is_x0; end
            default: w = 1'b0;
        endcase
        e.data  = ref_mem[idx];
        e.wid   = req_wid;
        e.tmask = req_tmask;
        e.rd    = req_rd;
        e.wb    = req_wb;
        e.write = w;
        e.waddr = req_addr;
        e.wdata = nv[11:0];
        if (w) begin
            ref_mem[idx] = {20'd0, nv[11:0]};
            exp_writes++;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compare every retiring response and any write it carries
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_meta", {rsp_wid, rsp_tmask, rsp_rd, rsp_wb}, {e.wid, e.tmask, e.rd, e.wb});
                    check("wr_en", csr_write_enable, e.write);
                    if (e.write)
                        check("wr_target", {csr_write_wid, csr_write_addr, csr_write_data},
                              {e.wid, e.waddr, e.wdata});
                end
            end else if (csr_write_enable) begin
                check("wr_en_idle", csr_write_enable, 1'b0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic preload(input logic [1:0] wid, input logic [11:0] addr, input logic [31:0] val);
        pre_we  = 1'b1;
        pre_idx = {wid, addr};
        pre_val = val;
        ref_mem[{wid, addr}] = val;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic drive_req(input logic [1:0] wid, input logic [1:0] op, input logic use_imm,
                             input logic [4:0] imm, input logic [31:0] rs1, input logic x0,
                             input logic [11:0] addr, input logic [4:0] rd, input logic [3:0] tmask);
        req_valid     = 1'b1;
        req_wid       = wid;
        req_op        = op;
        req_use_imm   = use_imm;
        req_imm       = imm;
        req_rs1_data  = rs1;
        req_rs1_is_x0 = x0;
        req_addr      = addr;
        req_rd        = rd;
        req_wb        = (rd != 5'd0);
        req_tmask     = tmask;
    endtask

    // Wait (bounded) for the driven request to be accepted; returns stall cycles.
    task automatic wait_accept(output int stalls);
        stalls = 0;
        #1;
        while (!req_ready && stalls < 50) begin
            @(negedge clk);
            if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            stalls++;
        end
        if (!req_ready) begin
            check("accept_timeout", req_ready, 1'b1);
            req_valid = 1'b0;
        end else begin
            predict();
            @(negedge clk);
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    // Hard stop if the run ever stalls completely.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed and random tests ----------------
    initial begin
        int st;
        int base_wr;
        int n;
        for (int i = 0; i < 16384; i++) ref_mem[i] = 32'd0;
        reset = 1'b1;
        rsp_ready = 1'b1;
        fpu_pending = 4'b0000;
        drive_req(2'd0, OP_RW, 1'b0, 5'd0, 32'd0, 1'b0, 12'h000, 5'd0, 4'd0);
        req_valid = 1'b0;
        mem_clear = 1'b1;
        repeat (2) @(negedge clk);
        mem_clear = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_en", csr_read_enable, 1'b0);
        check("rst_wr_en", csr_write_enable, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // CSRRS set bits: old 0x0F0 | 0xF0F -> 0xFFF, write in the response cycle
        preload(2'd0, 12'h340, 32'h0000_00F0);
        drive_req(2'd0, OP_RS, 1'b0, 5'd0, 32'h0000_0F0F, 1'b0, 12'h340, 5'd7, 4'b1011);
        wait_accept(st);
        req_valid = 1'b0;
        #1;
        check("rs_latency", rsp_valid, 1'b1);
        check("rs_write_with_rsp", csr_write_enable, 1'b1);
        @(negedge clk);

        // CSRRCI with zimm=0: read only
        preload(2'd0, 12'h300, 32'h0000_0123);
        drive_req(2'd0, OP_RC, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 12'h300, 5'd3, 4'b0001);
        wait_accept(st);
        idle();

        // Back-to-back CSRRW on the same CSR: one RAW stall cycle each
        drive_req(2'd1, OP_RW, 1'b0, 5'd0, 32'h0000_0AAA, 1'b0, 12'h300, 5'd4, 4'b1111);
        wait_accept(st);
        check("b2b_first_stall", st, 0);
        drive_req(2'd1, OP_RW, 1'b0, 5'd0, 32'h0000_0555, 1'b0, 12'h300, 5'd5, 4'b1111);
        wait_accept(st);
        check("b2b_raw_stall", st, 1);
        drive_req(2'd1, OP_RS, 1'b0, 5'd0, 32'h0, 1'b1, 12'h300, 5'd6, 4'b0011);
        wait_accept(st);
        check("b2b_readback_stall", st, 1);
        idle();

        // FPU-owned CSR: other warp proceeds, pending warp waits for the drop
        fpu_pending = 4'b0100;
        drive_req(2'd3, OP_RS, 1'b0, 5'd0, 32'h0, 1'b1, 12'h001, 5'd8, 4'b0100);
        wait_accept(st);
        check("fpu_other_warp_stall", st, 0);
        idle();
        drive_req(2'd2, OP_RS, 1'b0, 5'd0, 32'h0, 1'b1, 12'h001, 5'd8, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("fpu_stall_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        fpu_pending = 4'b0000;
        wait_accept(st);
        check("fpu_accept_after_drop", st, 0);
        idle();

        // Writeback backpressure: stage 1 holds, no write until release
        preload(2'd0, 12'h305, 32'h0000_00BC);
        rsp_ready = 1'b0;
        drive_req(2'd0, OP_RW, 1'b0, 5'd0, 32'h0000_01A5, 1'b0, 12'h305, 5'd9, 4'b1000);
        wait_accept(st);
        drive_req(2'd0, OP_RS, 1'b0, 5'd0, 32'h0, 1'b1, 12'h306, 5'd10, 4'b1000);
        base_wr = wr_count;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_data", rsp_data, 32'h0000_00BC);
            check("hold_rd", rsp_rd, 5'd9);
            check("hold_no_write", csr_write_enable, 1'b0);
            check("hold_req_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        wait_accept(st);
        check("hold_release_accept", st, 0);
        check("hold_write_once", wr_count - base_wr, 1);
        idle();

        // Reset with an instruction in flight drops it without a write
        preload(2'd0, 12'h301, 32'h0000_0042);
        rsp_ready = 1'b0;
        drive_req(2'd0, OP_RW, 1'b0, 5'd0, 32'h0000_0777, 1'b0, 12'h301, 5'd11, 4'b0010);
        wait_accept(st);
        req_valid = 1'b0;
        #1;
        check("inflight_valid", rsp_valid, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        ref_mem[{2'd0, 12'h301}] = 32'h0000_0042;
        exp_writes--;
        base_wr = wr_count;
        @(negedge clk);
        #1;
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        reset = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("midrst_no_write", wr_count - base_wr, 0);
        drive_req(2'd0, OP_RS, 1'b0, 5'd0, 32'h0, 1'b1, 12'h301, 5'd12, 4'b0010);
        wait_accept(st);
        idle();

        // Random mix of ops, operand sources and backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic        x0;
            logic [31:0] rs1;
            x0  = ($urandom_range(0, 3) == 0);
            rs1 = x0 ? 32'd0 : $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            drive_req(2'($urandom_range(0, 3)), 2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 31)), rs1, x0, 12'h340 + 12'($urandom_range(0, 3)),
                      5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
            wait_accept(st);
        end
        rand_rdy = 1'b0;
        rsp_ready = 1'b1;
        idle();

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        check("write_count", wr_count, exp_writes);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
